// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and defaults for the sprite blitter.
//   state_e        FSM state encoding
//   color_t        24-bit RGB colour
//   SCREEN_W_DEF   default visible width  (640)
//   SCREEN_H_DEF   default visible height (480)
//   KEY_COLOR_DEF  default transparent colour (white)
//   coord_clipped  true when an 11-bit screen coordinate is off-screen
package sprite_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_EMIT    = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  typedef logic [23:0] color_t;

  localparam int     SCREEN_W_DEF  = 640;
  localparam int     SCREEN_H_DEF  = 480;
  localparam color_t KEY_COLOR_DEF = 24'hFFFFFF;

  // Bit 10 means the sum overflowed past 1023, which is never on-screen.
  function automatic logic coord_clipped(input logic [10:0] coord, input int limit);
    return coord[10] || (32'(coord) >= limit);
  endfunction

endpackage

// File: rtl/sprite_pixel_counter.sv
// sprite_pixel_counter: column/row walker over one sprite.
//   Clk, Reset_n  clock and synchronous active-low reset
//   clear         zero both counters
//   advance       step to the next pixel in raster order
//   col, row      current pixel position inside the sprite
//   last          current pixel is the bottom-right one
module sprite_pixel_counter #(
  parameter int SPR_W = 8,
  parameter int SPR_H = 8,
  parameter int COL_W = 3,
  parameter int ROW_W = 3
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             clear,
  input  logic             advance,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             last
);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             col_at_end;

  assign col_at_end = (col_q == COL_W'(SPR_W - 1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (advance) begin
      if (col_at_end) begin
        col_d = '0;
        row_d = row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign last = col_at_end && (row_q == ROW_W'(SPR_H - 1));

endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter: walks one SPR_W x SPR_H sprite out of a 1-cycle-latency ROM,
// translates each pixel to screen space, clips it, optionally colour-keys it,
// and offers surviving pixels on a valid/ready port.
//   Clk, Reset_n             clock, synchronous active-low reset
//   start, spr_x, spr_y,     sprite request; position and ROM base latched
//   base_addr                when start is accepted in IDLE
//   busy, done               busy from accept until DONE exits; done pulse
//   read_address, rom_data   ROM request (registered) / colour one cycle later
//   px_valid, px_ready       pixel handshake
//   px_x, px_y, px_color     pixel payload, stable while px_valid is high
// Build option: define SPRITE_KEY_EN to drop pixels equal to KEY_COLOR.
//
// state   | meaning
// IDLE    | waiting for start
// ISSUE   | present ROM address for current pixel
// CAPTURE | take ROM colour, compute screen position, decide drop/emit
// EMIT    | offer pixel until px_ready
// DONE    | one-cycle done pulse, then back to IDLE
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int     SPR_W     = 8,
  parameter int     SPR_H     = 8,
  parameter int     ADDR_W    = 19,
  parameter int     SCREEN_W  = SCREEN_W_DEF,
  parameter int     SCREEN_H  = SCREEN_H_DEF,
  parameter color_t KEY_COLOR = KEY_COLOR_DEF
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic [9:0]        spr_x,
  input  logic [9:0]        spr_y,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] read_address,
  input  color_t            rom_data,
  output logic              px_valid,
  input  logic              px_ready,
  output logic [9:0]        px_x,
  output logic [9:0]        px_y,
  output color_t            px_color
);

  localparam int COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int ROW_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;

`ifdef SPRITE_KEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              px_valid_q, px_valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [9:0]        px_x_q, px_x_d;
  logic [9:0]        px_y_q, px_y_d;
  color_t            px_color_q, px_color_d;
  logic [9:0]        spr_x_q, spr_x_d;
  logic [9:0]        spr_y_q, spr_y_d;
  logic [ADDR_W-1:0] base_q, base_d;

  logic             cnt_clear, cnt_adv, cnt_last;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [10:0]      x_sum, y_sum;
  logic             drop;

  sprite_pixel_counter #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_counter (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .clear   (cnt_clear),
    .advance (cnt_adv),
    .col     (col),
    .row     (row),
    .last    (cnt_last)
  );

  assign x_sum = {1'b0, spr_x_q} + 11'(col);
  assign y_sum = {1'b0, spr_y_q} + 11'(row);
  assign drop  = coord_clipped(x_sum, SCREEN_W) || coord_clipped(y_sum, SCREEN_H) ||
                 (KEY_EN && (rom_data == KEY_COLOR));

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    px_valid_d = px_valid_q;
    addr_d     = addr_q;
    px_x_d     = px_x_q;
    px_y_d     = px_y_q;
    px_color_d = px_color_q;
    spr_x_d    = spr_x_q;
    spr_y_d    = spr_y_q;
    base_d     = base_q;
    cnt_clear  = 1'b0;
    cnt_adv    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          spr_x_d   = spr_x;
          spr_y_d   = spr_y;
          base_d    = base_addr;
          cnt_clear = 1'b1;
          busy_d    = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        addr_d  = base_q + ADDR_W'(row) * ADDR_W'(SPR_W) + ADDR_W'(col);
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        px_color_d = rom_data;
        px_x_d     = x_sum[9:0];
        px_y_d     = y_sum[9:0];
        if (drop) begin
          cnt_adv = 1'b1;
          if (cnt_last) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          px_valid_d = 1'b1;
          state_d    = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (px_ready) begin
          px_valid_d = 1'b0;
          cnt_adv    = 1'b1;
          if (cnt_last) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d     = 1'b0;
        px_valid_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      px_valid_q <= 1'b0;
      addr_q     <= '0;
      px_x_q     <= '0;
      px_y_q     <= '0;
      px_color_q <= '0;
      spr_x_q    <= '0;
      spr_y_q    <= '0;
      base_q     <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      px_valid_q <= px_valid_d;
      addr_q     <= addr_d;
      px_x_q     <= px_x_d;
      px_y_q     <= px_y_d;
      px_color_q <= px_color_d;
      spr_x_q    <= spr_x_d;
      spr_y_q    <= spr_y_d;
      base_q     <= base_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign px_valid     = px_valid_q;
  assign read_address = addr_q;
  assign px_x         = px_x_q;
  assign px_y         = px_y_q;
  assign px_color     = px_color_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: directed vectors for sprite_blitter with a combinational
// 1-cycle-latency ROM model. Expected counts depend on SPRITE_KEY_EN.
module tb_sprite_blitter;

`ifdef SPRITE_KEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        start;
  logic [9:0]  spr_x, spr_y;
  logic [18:0] base_addr;
  logic        busy, done;
  logic [18:0] read_address;
  logic [23:0] rom_data;
  logic        px_valid, px_ready;
  logic [9:0]  px_x, px_y;
  logic [23:0] px_color;

  always #5 Clk = ~Clk;

  sprite_blitter dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .start        (start),
    .spr_x        (spr_x),
    .spr_y        (spr_y),
    .base_addr    (base_addr),
    .busy         (busy),
    .done         (done),
    .read_address (read_address),
    .rom_data     (rom_data),
    .px_valid     (px_valid),
    .px_ready     (px_ready),
    .px_x         (px_x),
    .px_y         (px_y),
    .px_color     (px_color)
  );

  // ROM: colour = address, or white at odd addresses in keyed mode.
  bit keyed_mode;
  function automatic logic [23:0] rom_color(input logic [18:0] a, input bit k);
    if (k && a[0]) return 24'hFFFFFF;
    return {5'b0, a};
  endfunction
  assign rom_data = rom_color(read_address, keyed_mode);

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] c;
  } pix_t;
  pix_t got_q[$];

  int edge_cnt = 0, start_edge = 0, done_edge = 0, done_cnt = 0;
  bit start_seen = 0;

  always @(posedge Clk) begin
    edge_cnt++;
    if (Reset_n && start && !start_seen) begin
      start_seen = 1;
      start_edge = edge_cnt;
    end
    if (done) begin
      done_cnt++;
      done_edge = edge_cnt;
    end
    if (Reset_n && px_valid && px_ready) got_q.push_back('{px_x, px_y, px_color});
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    done_cnt   = 0;
    start_seen = 0;
  endtask

  task automatic pulse_start(input int x, input int y, input logic [18:0] b);
    @(negedge Clk);
    spr_x     = 10'(x);
    spr_y     = 10'(y);
    base_addr = b;
    start     = 1'b1;
    @(negedge Clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int t = 0;
    while (done_cnt == 0 && t < budget) begin
      @(negedge Clk);
      t++;
    end
    if (done_cnt == 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, budget);
    end
    repeat (3) @(negedge Clk);
  endtask

  typedef struct {
    string       name;
    int          x, y;
    logic [18:0] base;
    bit          keyed;
    int          cnt;
    int          fx, fy, lx, ly;
    logic [23:0] fc, lc;
    int          cyc;
  } vec_t;

  function automatic vec_t mk(input string n, input int x, input int y, input logic [18:0] b,
                              input bit k, input int cnt, input int fx, input int fy,
                              input logic [23:0] fc, input int lx, input int ly,
                              input logic [23:0] lc, input int cyc);
    vec_t v;
    v.name = n; v.x = x; v.y = y; v.base = b; v.keyed = k; v.cnt = cnt;
    v.fx = fx; v.fy = fy; v.fc = fc; v.lx = lx; v.ly = ly; v.lc = lc; v.cyc = cyc;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int idx, mism;
    clear_mon();
    keyed_mode = v.keyed;
    pulse_start(v.x, v.y, v.base);
    wait_done(v.name, 1000);
    check({v.name, "_count"}, got_q.size(), v.cnt);
    check({v.name, "_cycles"}, done_edge - start_edge, v.cyc);
    check({v.name, "_done_pulses"}, done_cnt, 1);
    if (v.cnt > 0) begin
      check({v.name, "_first_x"}, got_q[0].x, v.fx);
      check({v.name, "_first_y"}, got_q[0].y, v.fy);
      check({v.name, "_first_c"}, got_q[0].c, v.fc);
      check({v.name, "_last_x"}, got_q[got_q.size()-1].x, v.lx);
      check({v.name, "_last_y"}, got_q[got_q.size()-1].y, v.ly);
      check({v.name, "_last_c"}, got_q[got_q.size()-1].c, v.lc);
    end
    idx = 0;
    mism = 0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        int          sx, sy;
        logic [18:0] a;
        logic [23:0] col;
        sx  = v.x + c;
        sy  = v.y + r;
        a   = v.base + 19'(r * 8 + c);
        col = rom_color(a, v.keyed);
        if (!(sx >= 640 || sy >= 480 || (KEY_EN && col == 24'hFFFFFF))) begin
          if (idx >= got_q.size()) mism++;
          else if (got_q[idx].x != 10'(sx) || got_q[idx].y != 10'(sy) || got_q[idx].c != col)
            mism++;
          idx++;
        end
      end
    end
    if (idx != got_q.size()) mism++;
    check({v.name, "_pixel_stream_mismatches"}, mism, 0);
  endtask

  vec_t vecs[6];

  initial begin
    int          t, stable;
    logic [9:0]  hx, hy;
    logic [23:0] hc;

    vecs[0] = mk("opaque", 100, 50, 19'h0, 0, 64, 100, 50, 24'h0, 107, 57, 24'h3F, 193);
`ifdef SPRITE_KEY_EN
    vecs[1] = mk("keyed", 10, 20, 19'h100, 1, 32, 10, 20, 24'h100, 16, 27, 24'h13E, 161);
`else
    vecs[1] = mk("keyed", 10, 20, 19'h100, 1, 64, 10, 20, 24'h100, 17, 27, 24'hFFFFFF, 193);
`endif
    vecs[2] = mk("corner_clip", 636, 476, 19'h0, 0, 16, 636, 476, 24'h0, 639, 479, 24'h1B, 145);
    vecs[3] = mk("addr_wrap", 0, 0, 19'h7FFF0, 0, 64, 0, 0, 24'h07FFF0, 7, 7, 24'h2F, 193);
    vecs[4] = mk("x_overflow", 1020, 100, 19'h0, 0, 0, 0, 0, 24'h0, 0, 0, 24'h0, 129);
    vecs[5] = mk("bottom_clip", 5, 475, 19'h0, 0, 40, 5, 475, 24'h0, 12, 479, 24'h27, 169);

    Reset_n = 1'b0; start = 1'b0; spr_x = '0; spr_y = '0; base_addr = '0;
    px_ready = 1'b1; keyed_mode = 0;
    repeat (3) @(negedge Clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_px_valid", px_valid, 0);
    check("rst_read_address", read_address, 0);
    check("rst_px_x", px_x, 0);
    check("rst_px_y", px_y, 0);
    check("rst_px_color", px_color, 0);
    Reset_n = 1'b1;
    @(negedge Clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Backpressure on the first pixel.
    clear_mon();
    keyed_mode = 0;
    px_ready = 1'b0;
    pulse_start(200, 100, 19'h0);
    t = 0;
    while (!px_valid && t < 50) begin
      @(negedge Clk);
      t++;
    end
    check("stall_valid_seen", px_valid, 1);
    hx = px_x; hy = px_y; hc = px_color;
    check("stall_first_x", hx, 200);
    check("stall_first_y", hy, 100);
    check("stall_first_c", hc, 0);
    stable = 0;
    for (int i = 0; i < 5; i++) begin
      if (px_valid && px_x == hx && px_y == hy && px_color == hc) stable++;
      @(negedge Clk);
    end
    check("stall_stable_cycles", stable, 5);
    check("stall_no_transfer", got_q.size(), 0);
    px_ready = 1'b1;
    wait_done("stall", 1000);
    check("stall_count", got_q.size(), 64);
    check("stall_q0_x", got_q[0].x, 200);
    check("stall_q1_x", got_q[1].x, 201);

    // Start while busy is ignored.
    clear_mon();
    pulse_start(300, 200, 19'h0);
    repeat (10) @(negedge Clk);
    pulse_start(0, 0, 19'h5);
    wait_done("restart", 1000);
    repeat (10) @(negedge Clk);
    check("restart_done_pulses", done_cnt, 1);
    check("restart_count", got_q.size(), 64);
    check("restart_first_x", got_q[0].x, 300);
    check("restart_first_y", got_q[0].y, 200);
    check("restart_last_x", got_q[63].x, 307);
    check("restart_last_y", got_q[63].y, 207);
    check("restart_idle_busy", busy, 0);

    // Reset in the middle of pixel 20.
    clear_mon();
    pulse_start(100, 50, 19'h0);
    t = 0;
    while (got_q.size() < 20 && t < 500) begin
      @(negedge Clk);
      t++;
    end
    check("midrst_reached_px20", got_q.size(), 20);
    Reset_n = 1'b0;
    @(negedge Clk);
    check("midrst_busy", busy, 0);
    check("midrst_px_valid", px_valid, 0);
    check("midrst_read_address", read_address, 0);
    check("midrst_done", done, 0);
    Reset_n = 1'b1;
    repeat (20) @(negedge Clk);
    check("midrst_no_done", done_cnt, 0);
    run_vec(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Initiator side of the sprite ROM interface: on a start pulse, walks every pixel of one SPR_W×SPR_H sprite, issues `read_address` to a palette-decoded sprite ROM, and captures the 24-bit colour returned one clock later. Each pixel is translated to screen coordinates, clipped, optionally colour-keyed, and streamed to the frame-buffer writer over a valid/ready pixel port. It sits between the game-logic sprite list and the frame buffer, one instance per drawing engine.

## Interface
- SPR_W, 8, sprite width in pixels (power of two)
- SPR_H, 8, sprite height in pixels
- ADDR_W, 19, sprite ROM address width
- SCREEN_W, 640, visible width; x ≥ SCREEN_W clipped
- SCREEN_H, 480, visible height; y ≥ SCREEN_H clipped
- KEY_COLOR, 24'hFFFFFF, transparent colour
- Clk  in  1  single clock; all logic on posedge
- Reset_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- spr_x  in  10  screen x of sprite top-left, latched on accepted start
- spr_y  in  10  screen y of sprite top-left, latched on accepted start
- base_addr  in  ADDR_W  ROM address of pixel (0,0), latched on accepted start
- busy  out  1  high from cycle after accepted start until DONE exits
- done  out  1  one-cycle pulse at end of sprite
- read_address  out  ADDR_W  ROM address, registered
- rom_data  in  24  ROM colour, valid the cycle after read_address is presented
- px_valid  out  1  pixel offered
- px_ready  in  1  frame-buffer writer accepts
- px_x  out  10  pixel screen x
- px_y  out  10  pixel screen y
- px_color  out  24  pixel colour

## Operation
- FSM states IDLE, ISSUE, CAPTURE, EMIT, DONE.
- IDLE: start=1 → latch spr_x/spr_y/base_addr, clear row/col, go ISSUE. start in any other state ignored.
- ISSUE: read_address ← base + row·SPR_W + col; go CAPTURE.
- CAPTURE: latch rom_data into px_color, px_x ← spr_x+col, px_y ← spr_y+row. Pixel dropped if clipped or (keying enabled and rom_data == KEY_COLOR); dropped → advance; else go EMIT.
- EMIT: px_valid=1; px_x/px_y/px_color held stable until px_ready=1 on a clock edge; then advance.
- Advance: col+1; at col=SPR_W−1 wrap col to 0, row+1; after last pixel (row=SPR_H−1, col=SPR_W−1) go DONE, else ISSUE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Arithmetic: screen coords computed 11 bits wide; clip if bit 10 set or value ≥ SCREEN_W/SCREEN_H. Address sum in ADDR_W bits, wraps modulo 2^ADDR_W.

## Timing
- Reset (Reset_n=0 at edge): state IDLE, busy=0, done=0, px_valid=0, read_address=0, px_x=0, px_y=0, px_color=0, counters 0. Reset mid-sprite aborts; no done pulse; px_valid low the cycle after.
- ROM latency fixed at 1: address registered at edge N, rom_data sampled at edge N+1.
- Opaque pixel: 3 cycles minimum (ISSUE, CAPTURE, EMIT with px_ready=1); dropped pixel: 2 cycles.
- Full opaque 8×8 sprite, px_ready tied high: start edge to done pulse = 1+192 cycles.
- px_ready high outside EMIT has no effect; px_valid never deasserts before handshake.

## Configuration
- SPRITE_KEY_EN defined: pixels equal to KEY_COLOR dropped in CAPTURE (2-cycle path).
- Not defined: no keying; every unclipped pixel emitted, including KEY_COLOR.

## Structure
- Package sprite_pkg: state enum type, SCREEN_W/SCREEN_H defaults, KEY_COLOR default, 24-bit colour typedef.
- Sub-module sprite_pixel_counter: row/col counters with clear, advance, last-pixel flag.

## Test plan
- Opaque 8×8, spr_x=100, spr_y=50, base 0, px_ready=1 → 64 pixels, first (100,50) addr 0, last (107,57) addr 63, done at cycle 193.
- Keyed sprite, half pixels FFFFFF, SPRITE_KEY_EN defined → 32 pixels emitted, no FFFFFF; undefined → 64 emitted.
- spr_x=636, spr_y=476 → only 16 pixels (x 636–639, y 476–479) emitted; rest clipped.
- px_ready held low 5 cycles on first pixel → px_valid/x/y/color stable all 5 cycles, one transfer only.
- start pulsed again while busy → ignored, single done pulse, original coordinates used.
- Reset_n low during pixel 20 → next cycle busy=0, px_valid=0, read_address=0, no done; new start completes normally.
